if_stage: RTL and testbench



---
 rtl/if_stage_pkg.sv | 24 ++
 rtl/if_stage_perf_counter.sv | 24 ++
 rtl/if_stage.sv | 93 +++++++++
 tb/tb_if_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared pipeline constants for the fetch stage and its consumers.
package if_stage_pkg;

  localparam int unsigned FS_TO_DS_BUS_W = 65;

  // Field offsets inside the IF->ID bus: {adef, pc, inst}
  localparam int unsigned ADEF_BIT = 64;
  localparam int unsigned PC_MSB   = 63;
  localparam int unsigned PC_LSB   = 32;
  localparam int unsigned INST_MSB = 31;
  localparam int unsigned INST_LSB = 0;

  // Instruction forced into the slot when the fetch address faulted
  localparam logic [31:0] PKG_NOP_INST = 32'h0340_0000;

  // Exception code reported downstream for an instruction-fetch address error
  localparam logic [5:0] ECODE_ADEF = 6'h08;

  typedef enum logic {
    FS_EMPTY = 1'b0,
    FS_FULL  = 1'b1
  } fs_state_e;

endpackage

// File: rtl/if_stage_perf_counter.sv
// Free-running event counter: increments on en, wraps silently.
module perf_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count enabled events; wrap modulo 2^W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: registers the pre-IF pc/inst pair into a single slot, hands it
// to ID over valid/allowin, back-pressures pre-IF and drops it on redirects.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = PKG_NOP_INST,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pf_valid,
  input  logic [31:0]               pf_pc,
  input  logic                      pf_excp_adef,
  input  logic [31:0]               inst_sram_rdata,
  input  logic                      br_taken_cancel,
  input  logic                      excp_flush,
  input  logic                      ertn_flush,
  input  logic                      ds_allowin,
  output logic                      stall,
  output logic                      fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus,
  output logic [CNT_W-1:0]          fs_inst_cnt,
  output logic [CNT_W-1:0]          fs_flush_cnt
);

  fs_state_e   state;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_adef;

  logic fs_valid;
  logic flush;
  logic fs_allowin;
  logic fs_load;

  // Any redirect source kills the slot; simultaneous sources are one flush.
  assign flush      = br_taken_cancel | excp_flush | ertn_flush;
  assign fs_valid   = (state == FS_FULL);
  assign fs_allowin = !fs_valid | ds_allowin;
  assign fs_load    = fs_allowin & pf_valid & !flush;

  // Pre-IF holds its pc while we cannot accept, so the SRAM data stays aligned.
  assign stall          = !fs_allowin;
  assign fs_to_ds_valid = fs_valid & !flush;

  // Slot state and payload; flush wins over load and hand-off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FS_EMPTY;
      fs_pc   <= '0;
      fs_inst <= '0;
      fs_adef <= 1'b0;
    end else begin
      if (flush) begin
        state <= FS_EMPTY;
      end else if (fs_load) begin
        state   <= FS_FULL;
        fs_pc   <= pf_pc;
        fs_adef <= pf_excp_adef;
        fs_inst <= pf_excp_adef ? NOP_INST : inst_sram_rdata;
      end else if (fs_valid && ds_allowin) begin
        state <= FS_EMPTY;
      end
    end
  end

  // Assemble the IF->ID payload from the slot registers.
  always_comb begin
    fs_to_ds_bus                   = '0;
    fs_to_ds_bus[ADEF_BIT]         = fs_adef;
    fs_to_ds_bus[PC_MSB:PC_LSB]    = fs_pc;
    fs_to_ds_bus[INST_MSB:INST_LSB] = fs_inst;
  end

  perf_counter #(
    .W (CNT_W)
  ) u_inst_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (fs_to_ds_valid & ds_allowin),
    .count (fs_inst_cnt)
  );

  perf_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (fs_valid & flush),
    .count (fs_flush_cnt)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with hand-computed expectations.
module tb_if_stage;

  logic        clk;
  logic        clk_run;
  logic        reset;
  logic        pf_valid;
  logic [31:0] pf_pc;
  logic        pf_excp_adef;
  logic [31:0] inst_sram_rdata;
  logic        br_taken_cancel;
  logic        excp_flush;
  logic        ertn_flush;
  logic        ds_allowin;
  logic        stall;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic [31:0] fs_inst_cnt;
  logic [31:0] fs_flush_cnt;

  int unsigned n_checks;
  int unsigned n_pass;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .pf_valid        (pf_valid),
    .pf_pc           (pf_pc),
    .pf_excp_adef    (pf_excp_adef),
    .inst_sram_rdata (inst_sram_rdata),
    .br_taken_cancel (br_taken_cancel),
    .excp_flush      (excp_flush),
    .ertn_flush      (ertn_flush),
    .ds_allowin      (ds_allowin),
    .stall           (stall),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .fs_inst_cnt     (fs_inst_cnt),
    .fs_flush_cnt    (fs_flush_cnt)
  );

  // Gateable clock so reset can be exercised with no edges present.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clk = 1'b0; clk_run = 1'b1;
    reset = 1'b1;
    pf_valid = 1'b0; pf_pc = '0; pf_excp_adef = 1'b0; inst_sram_rdata = '0;
    br_taken_cancel = 1'b0; excp_flush = 1'b0; ertn_flush = 1'b0; ds_allowin = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_valid", 65'(fs_to_ds_valid), 65'd0);
    check("rst_bus",   fs_to_ds_bus, 65'd0);
    check("rst_stall", 65'(stall), 65'd0);
    check("rst_icnt",  65'(fs_inst_cnt), 65'd0);
    check("rst_fcnt",  65'(fs_flush_cnt), 65'd0);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back stream, one-cycle latency
    pf_valid = 1'b1; pf_pc = 32'h1c00_0000; inst_sram_rdata = 32'h1111_0000;
    tick();
    check("s1_valid", 65'(fs_to_ds_valid), 65'd1);
    check("s1_bus", fs_to_ds_bus, {1'b0, 32'h1c00_0000, 32'h1111_0000});
    pf_pc = 32'h1c00_0004; inst_sram_rdata = 32'h1111_0004;
    tick();
    check("s2_pc", 65'(fs_to_ds_bus[63:32]), 65'h1c00_0004);
    check("s2_icnt", 65'(fs_inst_cnt), 65'd1);
    pf_pc = 32'h1c00_0008; inst_sram_rdata = 32'h1111_0008;
    tick();
    check("s3_pc", 65'(fs_to_ds_bus[63:32]), 65'h1c00_0008);
    check("s3_icnt", 65'(fs_inst_cnt), 65'd2);
    pf_valid = 1'b0;
    tick();
    check("s4_valid", 65'(fs_to_ds_valid), 65'd0);
    check("s4_icnt", 65'(fs_inst_cnt), 65'd3);

    // Back-pressure: slot held, stall high for 3 cycles
    pf_valid = 1'b1; pf_pc = 32'h1c00_0010; inst_sram_rdata = 32'haaaa_0010;
    tick();
    ds_allowin = 1'b0; pf_pc = 32'h1c00_0014; inst_sram_rdata = 32'hdead_beef;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_stall", 65'(stall), 65'd1);
      check("hold_inst", 65'(fs_to_ds_bus[31:0]), 65'haaaa_0010);
      tick();
    end
    check("hold_bus", fs_to_ds_bus, {1'b0, 32'h1c00_0010, 32'haaaa_0010});
    check("hold_icnt", 65'(fs_inst_cnt), 65'd3);
    ds_allowin = 1'b1; inst_sram_rdata = 32'hbbbb_0014;
    #1;
    check("rel_stall", 65'(stall), 65'd0);
    tick();
    check("rel_bus", fs_to_ds_bus, {1'b0, 32'h1c00_0014, 32'hbbbb_0014});
    check("rel_icnt", 65'(fs_inst_cnt), 65'd4);

    // Branch flush while FULL and ID blocked
    ds_allowin = 1'b0; br_taken_cancel = 1'b1;
    pf_pc = 32'h1c00_0018; inst_sram_rdata = 32'heeee_0018;
    #1;
    check("br_valid_comb", 65'(fs_to_ds_valid), 65'd0);
    tick();
    br_taken_cancel = 1'b0; pf_pc = 32'h1c00_0100; inst_sram_rdata = 32'hcccc_0100;
    #1;
    check("br_empty", 65'(fs_to_ds_valid), 65'd0);
    check("br_fcnt", 65'(fs_flush_cnt), 65'd1);
    check("br_icnt", 65'(fs_inst_cnt), 65'd4);
    check("br_stall", 65'(stall), 65'd0);
    tick();
    check("br_target", fs_to_ds_bus, {1'b0, 32'h1c00_0100, 32'hcccc_0100});
    check("br_tvalid", 65'(fs_to_ds_valid), 65'd1);

    // Address-error fetch carries the flag and a NOP
    ds_allowin = 1'b1; pf_excp_adef = 1'b1; pf_pc = 32'h1c00_0002;
    inst_sram_rdata = 32'hdddd_0000;
    tick();
    check("adef_bus", fs_to_ds_bus, {1'b1, 32'h1c00_0002, 32'h0340_0000});
    check("adef_icnt0", 65'(fs_inst_cnt), 65'd5);
    pf_valid = 1'b0; pf_excp_adef = 1'b0;
    tick();
    check("adef_icnt1", 65'(fs_inst_cnt), 65'd6);
    check("adef_empty", 65'(fs_to_ds_valid), 65'd0);

    // Two redirects at once while EMPTY
    excp_flush = 1'b1; ertn_flush = 1'b1; pf_valid = 1'b1;
    pf_pc = 32'h1c00_0300; inst_sram_rdata = 32'hffff_0300;
    tick();
    excp_flush = 1'b0; ertn_flush = 1'b0; pf_valid = 1'b0;
    #1;
    check("dflush_valid", 65'(fs_to_ds_valid), 65'd0);
    check("dflush_fcnt", 65'(fs_flush_cnt), 65'd1);
    check("dflush_nocap", 65'(fs_to_ds_bus[63:32]), 65'h1c00_0002);

    // Counter wrap from all-ones
    force dut.u_inst_cnt.count_q = 32'hffff_ffff;
    #1;
    release dut.u_inst_cnt.count_q;
    #1;
    check("wrap_pre", 65'(fs_inst_cnt), 65'hffff_ffff);
    pf_valid = 1'b1; pf_pc = 32'h1c00_0200; inst_sram_rdata = 32'h1234_0200;
    tick();
    check("wrap_load", 65'(fs_inst_cnt), 65'hffff_ffff);
    pf_valid = 1'b0;
    tick();
    check("wrap_zero", 65'(fs_inst_cnt), 65'd0);

    // Asynchronous reset with the clock stopped
    pf_valid = 1'b1; pf_pc = 32'h1c00_0204; inst_sram_rdata = 32'h1234_0204;
    tick(); tick();
    check("pre_rst_valid", 65'(fs_to_ds_valid), 65'd1);
    check("pre_rst_icnt", 65'(fs_inst_cnt), 65'd1);
    clk_run = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("arst_valid", 65'(fs_to_ds_valid), 65'd0);
    check("arst_bus", fs_to_ds_bus, 65'd0);
    check("arst_icnt", 65'(fs_inst_cnt), 65'd0);
    check("arst_fcnt", 65'(fs_flush_cnt), 65'd0);
    pf_valid = 1'b0;
    #3;
    reset = 1'b0;
    clk_run = 1'b1;
    tick();
    check("post_rst_valid", 65'(fs_to_ds_valid), 65'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
